// File: rtl/motor_drive.sv
`default_nettype none
// ============================================================================
// Module   : motor_drive
// Function : Two-wheel PWM / H-bridge driver with duty ramping and
//            dead-time protected direction reversal.
// Revision : 1.0 - initial release
// ============================================================================
module motor_drive #(
    parameter int PWM_PERIOD       = 1000,
    parameter int RAMP_STEP_CYCLES = 50_000,
    parameter int DUTY_STEP        = 10,
    parameter int DUTY_FULL        = 1000,
    parameter int DUTY_VEER        = 700,
    parameter int DUTY_HARD        = 400,
    parameter int DEAD_TIME        = 25_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] DIR,
    input  logic       direction,
    output logic       L_EN,
    output logic       L_IN1,
    output logic       L_IN2,
    output logic       R_EN,
    output logic       R_IN1,
    output logic       R_IN2,
    output logic       moving
);

    localparam logic [15:0] c_pwm_last  = 16'(PWM_PERIOD - 1);
    localparam logic [15:0] c_ramp_last = 16'(RAMP_STEP_CYCLES - 1);
    localparam logic [15:0] c_step      = 16'(DUTY_STEP);
    localparam logic [15:0] c_full      = 16'(DUTY_FULL);
    localparam logic [15:0] c_veer      = 16'(DUTY_VEER);
    localparam logic [15:0] c_hard      = 16'(DUTY_HARD);
    localparam logic [15:0] c_dead_last = 16'(DEAD_TIME - 1);

    localparam logic [1:0] c_S_RUN       = 2'd0;
    localparam logic [1:0] c_S_RAMP_DOWN = 2'd1;
    localparam logic [1:0] c_S_DEAD      = 2'd2;

    logic [3:0]  r_cmd;
    logic        r_fwd_cmd;
    logic [15:0] r_pwm_cnt;
    logic [15:0] r_pre_cnt;
    logic        w_pwm_wrap;
    logic        w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd     <= 4'b1111;
            r_fwd_cmd <= 1'b1;
            r_pwm_cnt <= 16'd0;
            r_pre_cnt <= 16'd0;
        end else begin
            r_cmd     <= DIR;
            r_fwd_cmd <= direction;
            r_pwm_cnt <= w_pwm_wrap ? 16'd0 : r_pwm_cnt + 16'd1;
            r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
        end
    end

    assign w_pwm_wrap = (r_pwm_cnt == c_pwm_last);
    assign w_tick     = (r_pre_cnt == c_ramp_last);

    // Index 0 is the left wheel, index 1 the right wheel.
    logic             w_cmd_valid;
    logic [1:0][15:0] w_tgt_duty;
    logic [1:0]       w_tgt_raw_fwd;

    always_comb begin
        w_cmd_valid   = 1'b1;
        w_tgt_duty    = '0;
        w_tgt_raw_fwd = 2'b11;
        case (r_cmd)
            4'b0000: w_tgt_duty = {c_full, c_full};
            4'b1001: w_tgt_duty = {c_veer, c_full};
            4'b1010: w_tgt_duty = {c_hard, c_full};
            4'b1011: begin
                w_tgt_duty    = {c_full, c_full};
                w_tgt_raw_fwd = 2'b01;
            end
            4'b0101: w_tgt_duty = {c_full, c_veer};
            4'b0110: w_tgt_duty = {c_full, c_hard};
            4'b0111: begin
                w_tgt_duty    = {c_full, c_full};
                w_tgt_raw_fwd = 2'b10;
            end
            default: w_cmd_valid = 1'b0;
        endcase
    end

    logic [1:0][15:0] w_applied;
    logic [1:0]       w_en;
    logic [1:0][1:0]  w_in;

    for (genvar g = 0; g < 2; g++) begin : g_wheel
        logic [1:0]  r_state;
        logic        r_cur_fwd;
        logic [15:0] r_duty;
        logic [15:0] r_applied;
        logic [15:0] r_dead_cnt;
        logic [1:0]  r_in;
        logic        w_want_fwd;
        logic [15:0] w_eff;
        logic [15:0] w_duty_next;

        // Stop/invalid codes leave the wheel's direction alone.
        assign w_want_fwd = w_cmd_valid ? (w_tgt_raw_fwd[g] ~^ r_fwd_cmd) : r_cur_fwd;
        assign w_eff      = (r_state == c_S_RUN && w_want_fwd == r_cur_fwd) ?
                            w_tgt_duty[g] : 16'd0;

        always_comb begin
            w_duty_next = r_duty;
            if (r_duty < w_eff) begin
                w_duty_next = ((w_eff - r_duty) > c_step) ? r_duty + c_step : w_eff;
            end else if (r_duty > w_eff) begin
                w_duty_next = ((r_duty - w_eff) > c_step) ? r_duty - c_step : w_eff;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= c_S_RUN;
                r_cur_fwd  <= 1'b1;
                r_duty     <= 16'd0;
                r_applied  <= 16'd0;
                r_dead_cnt <= 16'd0;
                r_in       <= 2'b10;
            end else begin
                if (w_tick) begin
                    r_duty <= w_duty_next;
                end
                // Applied duty changes only on the period boundary.
                if (w_pwm_wrap) begin
                    r_applied <= r_duty;
                end
                case (r_state)
                    c_S_RUN: begin
                        if (w_want_fwd != r_cur_fwd) begin
                            r_state <= c_S_RAMP_DOWN;
                        end
                    end
                    c_S_RAMP_DOWN: begin
                        if (w_want_fwd == r_cur_fwd) begin
                            r_state <= c_S_RUN;
                        end else if (r_duty == 16'd0 && r_applied == 16'd0) begin
                            r_state    <= c_S_DEAD;
                            r_dead_cnt <= c_dead_last;
                            r_in       <= 2'b00;
                        end
                    end
                    c_S_DEAD: begin
                        if (r_dead_cnt == 16'd0) begin
                            r_state   <= c_S_RUN;
                            r_cur_fwd <= ~r_cur_fwd;
                            r_in      <= r_cur_fwd ? 2'b01 : 2'b10;
                        end else begin
                            r_dead_cnt <= r_dead_cnt - 16'd1;
                        end
                    end
                    default: r_state <= c_S_RUN;
                endcase
            end
        end

        assign w_applied[g] = r_applied;
        assign w_en[g]      = (r_state != c_S_DEAD) && (r_pwm_cnt < r_applied);
        assign w_in[g]      = r_in;
    end

    assign L_EN   = w_en[0];
    assign L_IN1  = w_in[0][1];
    assign L_IN2  = w_in[0][0];
    assign R_EN   = w_en[1];
    assign R_IN1  = w_in[1][1];
    assign R_IN2  = w_in[1][0];
    assign moving = (w_applied[0] != 16'd0) || (w_applied[1] != 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_motor_drive.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_drive
// Function : Directed self-checking bench for motor_drive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_drive;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] DIR;
    logic       direction;
    logic       L_EN, L_IN1, L_IN2, R_EN, R_IN1, R_IN2, moving;

    int n_checks = 0;
    int n_fail   = 0;

    motor_drive #(
        .PWM_PERIOD      (10),
        .RAMP_STEP_CYCLES(4),
        .DUTY_STEP       (3),
        .DUTY_FULL       (10),
        .DUTY_VEER       (6),
        .DUTY_HARD       (4),
        .DEAD_TIME       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .DIR      (DIR),
        .direction(direction),
        .L_EN     (L_EN),
        .L_IN1    (L_IN1),
        .L_IN2    (L_IN2),
        .R_EN     (R_EN),
        .R_IN1    (R_IN1),
        .R_IN2    (R_IN2),
        .moving   (moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dir;
        logic       fwd;
        int         l_cnt;
        int         r_cnt;
        logic [1:0] l_in;
        logic [1:0] r_in;
        logic       mv;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // EN-high cycles over one full PWM period equal the applied duty.
    task automatic measure(output int lc, output int rc);
        lc = 0;
        rc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lc += int'(L_EN);
            rc += int'(R_EN);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, rc, c0l, c0r, c1l, c1r, c2l, c2r;
        int dead_len, dead_en, rbad, zero_cnt, found;
        logic [1:0] after_dead;
        logic       got_after;

        tbl[0]  = '{4'b0000, 1'b1, 10, 10, 2'b10, 2'b10, 1'b1};
        tbl[1]  = '{4'b1001, 1'b1, 10,  6, 2'b10, 2'b10, 1'b1};
        tbl[2]  = '{4'b1010, 1'b1, 10,  4, 2'b10, 2'b10, 1'b1};
        tbl[3]  = '{4'b1011, 1'b1, 10, 10, 2'b10, 2'b01, 1'b1};
        tbl[4]  = '{4'b0101, 1'b1,  6, 10, 2'b10, 2'b10, 1'b1};
        tbl[5]  = '{4'b0110, 1'b1,  4, 10, 2'b10, 2'b10, 1'b1};
        tbl[6]  = '{4'b0111, 1'b1, 10, 10, 2'b01, 2'b10, 1'b1};
        tbl[7]  = '{4'b0000, 1'b0, 10, 10, 2'b01, 2'b01, 1'b1};
        tbl[8]  = '{4'b1001, 1'b0, 10,  6, 2'b01, 2'b01, 1'b1};
        tbl[9]  = '{4'b1011, 1'b0, 10, 10, 2'b01, 2'b10, 1'b1};
        tbl[10] = '{4'b1100, 1'b0,  0,  0, 2'b01, 2'b10, 1'b0};
        tbl[11] = '{4'b1111, 1'b1,  0,  0, 2'b01, 2'b10, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 10, 10, 2'b10, 2'b10, 1'b1};
        tbl[13] = '{4'b1000, 1'b1,  0,  0, 2'b10, 2'b10, 1'b0};
        tbl[14] = '{4'b0011, 1'b1,  0,  0, 2'b10, 2'b10, 1'b0};

        // Reset state and first ramp-up from standstill.
        rst = 1'b1;
        DIR = 4'b0000;
        direction = 1'b1;
        repeat (3) @(negedge clk);
        check("reset L_EN", int'(L_EN), 0);
        check("reset R_EN", int'(R_EN), 0);
        check("reset L_IN", int'({L_IN1, L_IN2}), 2);
        check("reset R_IN", int'({R_IN1, R_IN2}), 2);
        check("reset moving", int'(moving), 0);
        rst = 1'b0;
        c0l = 0; c0r = 0; c1l = 0; c1r = 0; c2l = 0; c2r = 0;
        // Duty is 6 at the first period boundary and 10 at the second.
        for (int k = 0; k < 29; k++) begin
            @(negedge clk);
            if (k < 9) begin
                c0l += int'(L_EN); c0r += int'(R_EN);
            end else if (k < 19) begin
                c1l += int'(L_EN); c1r += int'(R_EN);
            end else begin
                c2l += int'(L_EN); c2r += int'(R_EN);
            end
            if (k == 8) check("moving before first load", int'(moving), 0);
            if (k == 9) check("moving after first load", int'(moving), 1);
        end
        check("ramp L period0", c0l, 0);
        check("ramp R period0", c0r, 0);
        check("ramp L period1", c1l, 6);
        check("ramp R period1", c1r, 6);
        check("ramp L period2", c2l, 10);
        check("ramp R period2", c2r, 10);
        check("ramp L_IN", int'({L_IN1, L_IN2}), 2);
        check("ramp R_IN", int'({R_IN1, R_IN2}), 2);

        // Pivot left: left ramps down, dead for 3 cycles, then reverses.
        DIR = 4'b0111;
        dead_len = 0; dead_en = 0; rbad = 0; got_after = 1'b0; after_dead = 2'b11;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({L_IN1, L_IN2} == 2'b00) begin
                dead_len++;
                if (L_EN) dead_en++;
            end else if (dead_len > 0 && !got_after) begin
                after_dead = {L_IN1, L_IN2};
                got_after  = 1'b1;
            end
            if (!R_EN || {R_IN1, R_IN2} != 2'b10) rbad++;
        end
        check("pivot dead length", dead_len, 3);
        check("pivot EN during dead", dead_en, 0);
        check("pivot L_IN after dead", int'(after_dead), 1);
        check("pivot right disturbed", rbad, 0);
        measure(lc, rc);
        check("pivot L duty", lc, 10);
        check("pivot R duty", rc, 10);

        // Back to full forward, then a brief reversal request that is cancelled.
        DIR = 4'b0000;
        repeat (100) @(negedge clk);
        DIR = 4'b0111;
        repeat (6) @(negedge clk);
        DIR = 4'b0000;
        zero_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({L_IN1, L_IN2} == 2'b00) zero_cnt++;
        end
        check("cancelled reversal dead cycles", zero_cnt, 0);
        check("cancelled reversal L_IN", int'({L_IN1, L_IN2}), 2);
        measure(lc, rc);
        check("cancelled reversal L duty", lc, 10);

        // Reset while the left wheel sits in its dead time.
        DIR = 4'b0111;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if ({L_IN1, L_IN2} == 2'b00) found = 1;
        end
        check("reach left dead time", found, 1);
        rst = 1'b1;
        DIR = 4'b0000;
        @(negedge clk);
        check("mid-dead reset L_EN", int'(L_EN), 0);
        check("mid-dead reset R_EN", int'(R_EN), 0);
        check("mid-dead reset L_IN", int'({L_IN1, L_IN2}), 2);
        check("mid-dead reset R_IN", int'({R_IN1, R_IN2}), 2);
        check("mid-dead reset moving", int'(moving), 0);
        rst = 1'b0;
        zero_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ({L_IN1, L_IN2} == 2'b00) zero_cnt++;
        end
        check("post-reset no dead time", zero_cnt, 0);
        measure(lc, rc);
        check("post-reset L duty", lc, 10);

        // Steady-state decode table, applied in order from the state above.
        for (int v = 0; v < 15; v++) begin
            DIR = tbl[v].dir;
            direction = tbl[v].fwd;
            repeat (100) @(negedge clk);
            measure(lc, rc);
            check($sformatf("vec%0d L duty", v), lc, tbl[v].l_cnt);
            check($sformatf("vec%0d R duty", v), rc, tbl[v].r_cnt);
            check($sformatf("vec%0d L_IN", v), int'({L_IN1, L_IN2}), int'(tbl[v].l_in));
            check($sformatf("vec%0d R_IN", v), int'({R_IN1, R_IN2}), int'(tbl[v].r_in));
            check($sformatf("vec%0d moving", v), int'(moving), int'(tbl[v].mv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
